// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Fetch state encodings sit alongside the bus width constants.
package instr_fetch_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int BYTE_WIDTH = 8;

    typedef enum logic [1:0] {
        FETCH_LO   = 2'b00,
        FETCH_HI   = 2'b01,
        FETCH_HOLD = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: assembles little-endian 16-bit words from an 8-bit
// program memory and hands them to the decoder over valid/ready.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [BYTE_WIDTH-1:0] mem_data_in,
    input  logic                  mem_ready,
    output logic [WORD_WIDTH-1:0] word,
    output logic [ADDR_WIDTH-1:0] word_pc,
    output logic                  word_valid,
    input  logic                  word_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    localparam logic [ADDR_WIDTH-1:0] PC_ONE     = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PC_TWO     = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~PC_ONE;

    fetch_state_t          state_reg,      state_next;
    logic [ADDR_WIDTH-1:0] pc_reg,         pc_next;
    logic [BYTE_WIDTH-1:0] lo_byte_reg,    lo_byte_next;
    logic [WORD_WIDTH-1:0] word_reg,       word_next;
    logic [ADDR_WIDTH-1:0] word_pc_reg,    word_pc_next;
    logic                  word_valid_reg, word_valid_next;
    logic                  mem_rd_reg,     mem_rd_next;
    logic [ADDR_WIDTH-1:0] mem_addr_reg,   mem_addr_next;
    logic                  mem_access;

    // A read only completes while the request is actually on the bus.
    assign mem_access = mem_rd_reg && mem_ready;

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        lo_byte_next = lo_byte_reg;
        word_next    = word_reg;
        word_pc_next = word_pc_reg;

        if (redirect) begin
            state_next = FETCH_LO;
            pc_next    = redirect_pc & ALIGN_MASK;
        end else begin
            case (state_reg)
                FETCH_LO: begin
                    if (mem_access) begin
                        lo_byte_next = mem_data_in;
                        state_next   = FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (mem_access) begin
                        word_next    = {mem_data_in, lo_byte_reg};
                        word_pc_next = pc_reg;
                        pc_next      = pc_reg + PC_TWO;
                        state_next   = FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (word_valid_reg && word_ready) begin
                        state_next = FETCH_LO;
                    end
                end
                default: state_next = FETCH_LO;
            endcase
        end

        // Bus outputs are registered, so derive them from the upcoming state.
        word_valid_next = (state_next == FETCH_HOLD);
        mem_rd_next     = (state_next != FETCH_HOLD);
        mem_addr_next   = (state_next == FETCH_HI) ? (pc_next + PC_ONE) : pc_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= FETCH_LO;
            pc_reg         <= RESET_PC;
            lo_byte_reg    <= '0;
            word_reg       <= '0;
            word_pc_reg    <= RESET_PC;
            word_valid_reg <= 1'b0;
            mem_rd_reg     <= 1'b0;
            mem_addr_reg   <= RESET_PC;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            lo_byte_reg    <= lo_byte_next;
            word_reg       <= word_next;
            word_pc_reg    <= word_pc_next;
            word_valid_reg <= word_valid_next;
            mem_rd_reg     <= mem_rd_next;
            mem_addr_reg   <= mem_addr_next;
        end
    end

    assign mem_addr   = mem_addr_reg;
    assign mem_rd     = mem_rd_reg;
    assign word       = word_reg;
    assign word_pc    = word_pc_reg;
    assign word_valid = word_valid_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus randomized traffic
// checked every cycle against a word-level model of the fetch stream.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data_in;
    logic        mem_ready;
    logic [15:0] word;
    logic [15:0] word_pc;
    logic        word_valid;
    logic        word_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    logic [15:0] mem_addr_w;
    logic        mem_rd_w;
    logic [7:0]  mem_data_in_w;
    logic        mem_ready_w = 1'b1;
    logic [15:0] word_w;
    logic [15:0] word_pc_w;
    logic        word_valid_w;
    logic        word_ready_w = 1'b1;
    logic        redirect_w = 1'b0;
    logic [15:0] redirect_pc_w = 16'h0000;

    logic [7:0]  mem [0:65535];
    logic [7:0]  junk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_accept = 0;

    always #5 clk = ~clk;

    assign mem_data_in   = mem_ready ? mem[mem_addr] : junk;
    assign mem_data_in_w = mem[mem_addr_w];

    instr_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data_in(mem_data_in), .mem_ready(mem_ready), .word(word),
        .word_pc(word_pc), .word_valid(word_valid), .word_ready(word_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    instr_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'hFFFE)) dut_wrap (
        .clk(clk), .reset(reset), .mem_addr(mem_addr_w), .mem_rd(mem_rd_w),
        .mem_data_in(mem_data_in_w), .mem_ready(mem_ready_w), .word(word_w),
        .word_pc(word_pc_w), .word_valid(word_valid_w), .word_ready(word_ready_w),
        .redirect(redirect_w), .redirect_pc(redirect_pc_w)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] a1;
        a1 = a + 16'd1;
        return {mem[a1], mem[a]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        junk = 8'($urandom);
    endtask

    // Word-level model: exp_pc is the address of the next word the consumer
    // should see; it only moves on reset, redirect or an accepted word.
    logic [15:0] exp_pc      = 16'h0000;
    logic        prev_rst    = 1'b1;
    logic        prev_redir  = 1'b0;
    logic        prev_accept = 1'b0;
    logic        prev_stall  = 1'b0;
    logic        prev_hold   = 1'b0;
    logic [15:0] prev_addr   = 16'h0000;
    logic [15:0] prev_word   = 16'h0000;
    logic [15:0] prev_wpc    = 16'h0000;

    always @(negedge clk) begin
        if (prev_rst) begin
            check("rst_mem_rd", 32'(mem_rd), 32'd0);
            check("rst_valid", 32'(word_valid), 32'd0);
            check("rst_word", 32'(word), 32'd0);
            check("rst_word_pc", 32'(word_pc), 32'd0);
            check("rst_mem_addr", 32'(mem_addr), 32'd0);
        end else begin
            if (word_valid) begin
                check("word_pc", 32'(word_pc), 32'(exp_pc));
                check("word", 32'(word), 32'(mem_word(exp_pc)));
                check("no_rd_in_hold", 32'(mem_rd), 32'd0);
            end
            if (mem_rd) begin
                check("rd_addr_in_word",
                      32'((mem_addr == exp_pc) || (mem_addr == exp_pc + 16'd1)), 32'd1);
            end
            if (prev_stall) begin
                check("stall_rd", 32'(mem_rd), 32'd1);
                check("stall_addr", 32'(mem_addr), 32'(prev_addr));
            end
            if (prev_hold) begin
                check("hold_valid", 32'(word_valid), 32'd1);
                check("hold_word", 32'(word), 32'(prev_word));
                check("hold_pc", 32'(word_pc), 32'(prev_wpc));
            end
            if (prev_redir || prev_accept) begin
                check("restart_valid", 32'(word_valid), 32'd0);
                check("restart_rd", 32'(mem_rd), 32'd1);
                check("restart_addr", 32'(mem_addr), 32'(exp_pc));
            end
        end

        // Inputs now on the pins are what the next rising edge samples.
        prev_rst    = reset;
        prev_redir  = !reset && redirect;
        prev_accept = !reset && !redirect && word_valid && word_ready;
        prev_stall  = !reset && !redirect && mem_rd && !mem_ready;
        prev_hold   = !reset && !redirect && word_valid && !word_ready;
        prev_addr   = mem_addr;
        prev_word   = word;
        prev_wpc    = word_pc;
        if (reset) begin
            exp_pc = 16'h0000;
        end else if (redirect) begin
            exp_pc = {redirect_pc[15:1], 1'b0};
        end else if (word_valid && word_ready) begin
            exp_pc = exp_pc + 16'd2;
            n_accept++;
        end
    end

    int          w_seen = 0;
    logic [15:0] w_word [0:1];
    logic [15:0] w_pc   [0:1];

    always @(negedge clk) begin
        if (word_valid_w && w_seen < 2) begin
            w_word[w_seen] = word_w;
            w_pc[w_seen]   = word_pc_w;
            w_seen++;
        end
    end

    initial begin
        int n;
        int acc_start;
        reset       = 1'b1;
        mem_ready   = 1'b1;
        word_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        junk        = 8'h00;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h34; mem[1] = 8'h12; mem[2] = 8'h78; mem[3] = 8'h56;
        mem[16'hFFFE] = 8'hCD; mem[16'hFFFF] = 8'hAB;

        repeat (3) tick();
        check("reset_mem_rd", 32'(mem_rd), 32'd0);
        check("reset_word_valid", 32'(word_valid), 32'd0);

        // First word latency, then a 5-cycle consumer stall.
        reset = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!word_valid && n < 10);
        check("first_latency", 32'(n), 32'd3);
        check("first_word", 32'(word), 32'h1234);
        check("first_word_pc", 32'(word_pc), 32'h0000);
        repeat (5) begin
            tick();
            check("stall5_valid", 32'(word_valid), 32'd1);
            check("stall5_word", 32'(word), 32'h1234);
            check("stall5_rd", 32'(mem_rd), 32'd0);
        end
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        check("after_accept_addr", 32'(mem_addr), 32'h0002);
        n = 1;
        while (!word_valid && n < 10) begin tick(); n++; end
        check("second_latency", 32'(n), 32'd3);
        check("second_word", 32'(word), 32'h5678);
        check("second_word_pc", 32'(word_pc), 32'h0002);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;

        // Wait states on the high byte at address 1.
        redirect = 1'b1; redirect_pc = 16'h0000;
        tick();
        redirect = 1'b0;
        tick();
        mem_ready = 1'b0;
        repeat (4) begin
            tick();
            check("wait_addr", 32'(mem_addr), 32'h0001);
            check("wait_rd", 32'(mem_rd), 32'd1);
        end
        mem_ready = 1'b1;
        tick();
        check("wait_word", 32'(word), 32'h1234);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;

        // Redirect during the high-byte read; the completing byte is dropped.
        tick();
        check("pre_redir_addr", 32'(mem_addr), 32'h0003);
        redirect = 1'b1; redirect_pc = 16'h0101;
        tick();
        redirect = 1'b0;
        check("redir_hi_addr", 32'(mem_addr), 32'h0100);
        n = 0;
        while (!word_valid && n < 10) begin tick(); n++; end
        check("redir_hi_pc", 32'(word_pc), 32'h0100);
        check("redir_hi_word", 32'(word), 32'(mem_word(16'h0100)));

        // Redirect in HOLD coinciding with an accept.
        word_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0200;
        tick();
        redirect = 1'b0; word_ready = 1'b0;
        check("redir_hold_valid", 32'(word_valid), 32'd0);
        check("redir_hold_addr", 32'(mem_addr), 32'h0200);
        n = 0;
        while (!word_valid && n < 10) begin tick(); n++; end
        check("redir_hold_pc", 32'(word_pc), 32'h0200);

        // Steady-state throughput with both sides always ready.
        word_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin tick(); n++; end while (!word_valid && n < 10);
            check("throughput", 32'(n), 32'd3);
        end

        // Randomized traffic.
        acc_start = n_accept;
        for (int c = 0; c < 3000; c++) begin
            mem_ready   = ($urandom_range(0, 3) != 0);
            word_ready  = ($urandom_range(0, 2) != 0);
            redirect    = ($urandom_range(0, 39) == 0);
            redirect_pc = 16'($urandom);
            reset       = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; redirect = 1'b0;
        check("random_progress", 32'(n_accept - acc_start > 50), 32'd1);

        check("wrap_seen", 32'(w_seen), 32'd2);
        check("wrap_pc0", 32'(w_pc[0]), 32'hFFFE);
        check("wrap_word0", 32'(w_word[0]), 32'hABCD);
        check("wrap_pc1", 32'(w_pc[1]), 32'h0000);
        check("wrap_word1", 32'(w_word[1]), 32'h1234);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
